ucsbece154_sdram_ctrl: RTL and testbench
========================================

Name: ucsbece154_sdram_ctrl

Overview:
- Memory-side stage directly downstream of ucsbece154_icache. It services the cache's block-fill requests (MemReadRequest/MemReadAddress) from a word-addressed backing array.
- Each fill returns one block of WORDS_PER_BLOCK words on MemDataOut, qualified by MemDataReady, after a programmable first-word latency.
- Replaces the behavioural SDRAM stand-in so fills are synthesizable and timing-exact.

Parameters:
- ADDR_WIDTH, 32, byte-address width of MemReadAddress.
- DATA_WIDTH, 32, word width.
- WORDS_PER_BLOCK, 4, words per burst; power of 2, ≥1.
- FIRST_WORD_DELAY, 40, cycles from the acceptance edge to the first MemDataReady; ≥1.
- NEXT_WORD_DELAY, 1, cycles between successive words; 1 = back-to-back; ≥1.
- MEM_DEPTH, 256, backing array depth in words; power of 2.
- INIT_FILE, "text.dat", hex file loaded into the array at time 0 (simulation preload).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- MemReadRequest  input  1  fill request from the icache.
- MemReadAddress  input  ADDR_WIDTH  byte address of the requested fill.
- ReqAccepted  output  1  one-cycle pulse: request latched.
- Busy  output  1  high whenever state != IDLE.
- MemDataOut  output  DATA_WIDTH  returned word; 0 when MemDataReady is low.
- MemDataReady  output  1  MemDataOut valid this cycle.

Behaviour:
- Reset low (asynchronous, any time, including mid-burst): state=IDLE; ReqAccepted=0, Busy=0, MemDataReady=0, MemDataOut=0; counters cleared. Any burst in flight is abandoned with no further words. Array contents are unaffected.
- All outputs are registered.
- States: IDLE, WAIT, BURST.
- IDLE:
  - If MemReadRequest=1 at a rising edge: latch base word index = ((MemReadAddress>>2) & ~(WORDS_PER_BLOCK-1)) mod MEM_DEPTH.
  - Load delay counter = FIRST_WORD_DELAY-1, word index = 0.
  - ReqAccepted=1 for the following cycle only; go to WAIT.
- WAIT: decrement the counter each edge. At the edge where the counter is 0, go to BURST, present word 0 and set MemDataReady=1. The first word is therefore visible after edge FIRST_WORD_DELAY, counting the acceptance edge as edge 0.
- BURST:
  - Word k is output as mem[base+k] for exactly one cycle with MemDataReady=1.
  - Between words, NEXT_WORD_DELAY-1 gap cycles with MemDataReady=0 and MemDataOut=0.
  - The edge that ends the last word's cycle drops MemDataReady, returns to IDLE and clears Busy.
- Bursts never cross a block boundary. Word order is always base..base+WORDS_PER_BLOCK-1; no critical-word-first.
- Address bits above log2(MEM_DEPTH)+2 are ignored, so the index wraps modulo MEM_DEPTH.
- No request queue: MemReadRequest is ignored while Busy=1. The requester holds the request and address stable until it sees ReqAccepted.
- Earliest re-acceptance is the first edge after the return to IDLE. A request held continuously is accepted there, giving exactly one idle cycle between bursts.
- MemReadAddress is sampled only at the acceptance edge; later changes have no effect on the burst in flight.
- Words of a burst always come from the same latched base, regardless of input activity.
- Illegal parameter values (non-power-of-2 sizes, zero delays) are rejected at elaboration.

Test Plan:
- Preload mem[i]=0x10000000+i, default parameters. Reset low 2 cycles, then request 0x00000000: ReqAccepted pulses after edge 0, Busy high; MemDataReady high after edges 40,41,42,43 with 0x10000000..0x10000003; Busy low after edge 43.
- Request 0x0000001C: block-aligned to index 4; data 0x10000004..0x10000007 in order.
- Request 0x00000000, then at edge 10 change MemReadAddress to 0x00000040 and hold MemReadRequest high: first burst unchanged (0x10000000..03); second request accepted at edge 44; data 0x10000010..0x10000013 after edges 84..87.
- Request 0x00000400 (MEM_DEPTH=256): index wraps to 0; data 0x10000000..0x10000003.
- Drive Reset low mid-cycle after the 2nd word of a burst: MemDataReady, MemDataOut and Busy go to 0 immediately without waiting for a clock edge; no 3rd word appears. After release, request 0x00000020 completes normally with 0x10000008..0x1000000B.
- FIRST_WORD_DELAY=5, NEXT_WORD_DELAY=3: MemDataReady high only after edges 5, 8, 11, 14; MemDataOut=0 in the gap cycles.

Source files
------------

// File: rtl/ucsbece154_sdram_ctrl.sv
// Block-fill memory for ucsbece154_icache: accepts one fill request, waits a fixed
// first-word latency, then streams an aligned block of words from a backing array.
module ucsbece154_sdram_ctrl #(
  parameter int    ADDR_WIDTH       = 32,
  parameter int    DATA_WIDTH       = 32,
  parameter int    WORDS_PER_BLOCK  = 4,
  parameter int    FIRST_WORD_DELAY = 40,
  parameter int    NEXT_WORD_DELAY  = 1,
  parameter int    MEM_DEPTH        = 256,
  parameter string INIT_FILE        = "text.dat"
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MemReadRequest,
  input  logic [ADDR_WIDTH-1:0] MemReadAddress,
  output logic                  ReqAccepted,
  output logic                  Busy,
  output logic [DATA_WIDTH-1:0] MemDataOut,
  output logic                  MemDataReady
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int DMAX  = (FIRST_WORD_DELAY > NEXT_WORD_DELAY) ? FIRST_WORD_DELAY : NEXT_WORD_DELAY;
  localparam int DW    = $clog2(DMAX + 1);

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [IDX_W-1:0] BLK_MASK  = ~LAST_WORD;
  localparam logic [DW-1:0]    FIRST_LD  = DW'(FIRST_WORD_DELAY - 1);
  localparam logic [DW-1:0]    NEXT_LD   = DW'(NEXT_WORD_DELAY - 1);

  if (WORDS_PER_BLOCK < 1 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 ||
      MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 ||
      WORDS_PER_BLOCK > MEM_DEPTH || FIRST_WORD_DELAY < 1 || NEXT_WORD_DELAY < 1 ||
      ADDR_WIDTH < IDX_W + 2) begin : g_bad_params
    $error("ucsbece154_sdram_ctrl: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]      wd_q, wd_d;
  logic [IDX_W-1:0]      base_q, base_d;
  logic                  acc_d, rdy_d, present;
  logic [DATA_WIDTH-1:0] dout_d;

  // Address bits outside the word index only select bytes or alias the array.
  logic unused_addr;
  assign unused_addr = ^MemReadAddress;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wd_q         <= '0;
      base_q       <= '0;
      ReqAccepted  <= 1'b0;
      Busy         <= 1'b0;
      MemDataOut   <= '0;
      MemDataReady <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      base_q       <= base_d;
      ReqAccepted  <= acc_d;
      Busy         <= (state_d != IDLE);
      MemDataOut   <= dout_d;
      MemDataReady <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    base_d  = base_q;
    acc_d   = 1'b0;
    rdy_d   = 1'b0;
    dout_d  = '0;
    present = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemReadRequest) begin
          base_d  = MemReadAddress[IDX_W+1:2] & BLK_MASK;
          cnt_d   = FIRST_LD;
          wd_d    = '0;
          acc_d   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) present = 1'b1;
        else             cnt_d = cnt_q - DW'(1);
      end
      BURST: begin
        if (cnt_q == '0) begin
          wd_d    = wd_q + IDX_W'(1);
          present = 1'b1;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The last word leaves for IDLE on the same edge it is presented, so a
    // held request is re-accepted one edge later.
    if (present) begin
      rdy_d  = 1'b1;
      dout_d = mem[base_q + wd_d];
      if (wd_d == LAST_WORD) begin
        state_d = IDLE;
      end else begin
        state_d = BURST;
        cnt_d   = NEXT_LD;
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154_sdram_ctrl.sv
// Directed checks of ucsbece154_sdram_ctrl: default timing via a vector table, plus
// held-request, asynchronous-reset and custom-delay sequences.
module tb_ucsbece154_sdram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        acc0, busy0, rdy0;
    logic        acc1, busy1, rdy1;
    logic [31:0] dout0, dout1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucsbece154_sdram_ctrl #(
        .INIT_FILE("")
    ) dut0 (
        .Clk(clk), .Reset(rst_n),
        .MemReadRequest(req0), .MemReadAddress(addr0),
        .ReqAccepted(acc0), .Busy(busy0),
        .MemDataOut(dout0), .MemDataReady(rdy0)
    );

    ucsbece154_sdram_ctrl #(
        .FIRST_WORD_DELAY(5),
        .NEXT_WORD_DELAY(3),
        .INIT_FILE("")
    ) dut1 (
        .Clk(clk), .Reset(rst_n),
        .MemReadRequest(req1), .MemReadAddress(addr1),
        .ReqAccepted(acc1), .Busy(busy1),
        .MemDataOut(dout1), .MemDataReady(rdy1)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] first_word;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drives one request on dut0 and checks the full default-timing burst.
    task automatic run_burst(input logic [31:0] addr, input logic [31:0] first_word);
        req0  = 1'b1;
        addr0 = addr;
        for (int e = 0; e <= 44; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                chk("acc_pulse", {31'b0, acc0}, 32'd1);
                chk("busy_start", {31'b0, busy0}, 32'd1);
                req0  = 1'b0;
                addr0 = 32'hFFFF_FFFC;
            end else if (e < 40) begin
                chk("wait_rdy", {31'b0, rdy0}, 32'd0);
                if (e == 1) chk("acc_once", {31'b0, acc0}, 32'd0);
            end else if (e <= 43) begin
                chk("burst_rdy", {31'b0, rdy0}, 32'd1);
                chk("burst_data", dout0, first_word + 32'(e - 40));
                chk("burst_busy", {31'b0, busy0}, (e == 43) ? 32'd0 : 32'd1);
            end else begin
                chk("end_rdy", {31'b0, rdy0}, 32'd0);
                chk("end_data", dout0, 32'd0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{addr: 32'h0000_0000, first_word: 32'h1000_0000};
        vecs[1] = '{addr: 32'h0000_001C, first_word: 32'h1000_0004};
        vecs[2] = '{addr: 32'h0000_0400, first_word: 32'h1000_0000};
        vecs[3] = '{addr: 32'h0000_03FC, first_word: 32'h1000_00FC};
        vecs[4] = '{addr: 32'hABCD_0136, first_word: 32'h1000_004C};

        for (int i = 0; i < 256; i++) begin
            dut0.mem[i] = 32'h1000_0000 + 32'(i);
            dut1.mem[i] = 32'h1000_0000 + 32'(i);
        end

        rst_n = 1'b0;
        req0 = 1'b0; addr0 = '0;
        req1 = 1'b0; addr1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc", {31'b0, acc0}, 32'd0);
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_rdy", {31'b0, rdy0}, 32'd0);
        chk("rst_data", dout0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_burst(vecs[i].addr, vecs[i].first_word);

        // Held request with the address changing mid-burst.
        req0  = 1'b1;
        addr0 = 32'h0000_0000;
        for (int e = 0; e <= 88; e++) begin
            @(posedge clk); #1;
            if (e == 0) chk("held_acc0", {31'b0, acc0}, 32'd1);
            if (e >= 1 && e <= 43) chk("held_noacc", {31'b0, acc0}, 32'd0);
            if (e == 9) addr0 = 32'h0000_0040;
            if (e >= 40 && e <= 43) chk("held_data1", dout0, 32'h1000_0000 + 32'(e - 40));
            if (e == 43) chk("held_busy_lo", {31'b0, busy0}, 32'd0);
            if (e == 44) begin
                chk("held_acc1", {31'b0, acc0}, 32'd1);
                chk("held_gap_rdy", {31'b0, rdy0}, 32'd0);
                req0 = 1'b0;
            end
            if (e == 45) chk("held_acc1_once", {31'b0, acc0}, 32'd0);
            if (e == 83) chk("held_pre_rdy", {31'b0, rdy0}, 32'd0);
            if (e >= 84 && e <= 87) begin
                chk("held_rdy2", {31'b0, rdy0}, 32'd1);
                chk("held_data2", dout0, 32'h1000_0010 + 32'(e - 84));
            end
            if (e == 88) chk("held_end_rdy", {31'b0, rdy0}, 32'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset after the second word of a burst.
        req0  = 1'b1;
        addr0 = 32'h0000_0000;
        for (int e = 0; e <= 41; e++) begin
            @(posedge clk); #1;
            if (e == 0) req0 = 1'b0;
            if (e == 41) chk("pre_rst_data", dout0, 32'h1000_0001);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rdy", {31'b0, rdy0}, 32'd0);
        chk("async_data", dout0, 32'd0);
        chk("async_busy", {31'b0, busy0}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("in_rst_rdy", {31'b0, rdy0}, 32'd0);
        end
        rst_n = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            chk("post_rst_rdy", {31'b0, rdy0}, 32'd0);
            chk("post_rst_busy", {31'b0, busy0}, 32'd0);
        end
        run_burst(32'h0000_0020, 32'h1000_0008);

        // FIRST_WORD_DELAY=5, NEXT_WORD_DELAY=3 instance.
        req1  = 1'b1;
        addr1 = 32'h0000_0000;
        for (int e = 0; e <= 17; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                chk("d1_acc", {31'b0, acc1}, 32'd1);
                req1 = 1'b0;
            end
            if (e == 5 || e == 8 || e == 11 || e == 14) begin
                chk("d1_rdy", {31'b0, rdy1}, 32'd1);
                chk("d1_data", dout1, 32'h1000_0000 + 32'((e - 5) / 3));
            end else begin
                chk("d1_gap_rdy", {31'b0, rdy1}, 32'd0);
                chk("d1_gap_data", dout1, 32'd0);
            end
            chk("d1_busy", {31'b0, busy1}, (e < 14) ? 32'd1 : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
